fsmc_target: RTL and testbench

- FPGA-side responder for the STM32 FSMC asynchronous SRAM-style bus. The MCU is the initiator; this block is the responder.
- Synchronises the asynchronous FSMC pins into the `clk` domain and converts each completed write strobe or new read strobe into a single request on the internal memory port, which the SDRAM controller consumes.
- Returns read data to the pads and drives the tristate enable.
- Sits in `system` between the FSMC pins and the SDRAM controller; the top level performs the pad tristate (`fsmc_d = fsmc_d_oe ? fsmc_d_out : 'z`).

---
 rtl/fsmc_pkg.sv | 16 +
 rtl/fsmc_sync.sv | 26 ++
 rtl/fsmc_target.sv | 225 ++++++++++++++++++++++
 tb/tb_fsmc_target.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsmc_pkg.sv
// rtl/fsmc_pkg.sv - shared types and default widths for the FSMC responder
package fsmc_pkg;

  localparam int FSMC_ADDR_W      = 16;
  localparam int FSMC_DATA_W      = 16;
  localparam int FSMC_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    RD_WAIT,
    RD_HOLD
  } fsmc_state_t;

endpackage

// File: rtl/fsmc_sync.sv
// rtl/fsmc_sync.sv - STAGES-deep flop chain bringing FSMC pins into clk domain
module fsmc_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] chain [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= rst_val;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/fsmc_target.sv
// rtl/fsmc_target.sv - FSMC async SRAM-bus responder issuing single memory requests
// Optional NWAIT output enabled by defining FSMC_NWAIT_EN.
module fsmc_target
  import fsmc_pkg::*;
#(
  parameter int ADDR_W      = FSMC_ADDR_W,
  parameter int DATA_W      = FSMC_DATA_W,
  parameter int SYNC_STAGES = FSMC_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fsmc_a,
  input  logic [DATA_W-1:0] fsmc_d_in,
  output logic [DATA_W-1:0] fsmc_d_out,
  output logic              fsmc_d_oe,
  input  logic              fsmc_ne1,
  input  logic              fsmc_nwe,
  input  logic              fsmc_noe,
  input  logic              fsmc_nbl1,
  input  logic              fsmc_nbl0,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  output logic [1:0]        req_be,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic              err_sticky
`ifdef FSMC_NWAIT_EN
  ,
  output logic              fsmc_nwait
`endif
);

  localparam int AD_W = ADDR_W + DATA_W;

  // strobe vector layout: {ne1, nwe, noe, nbl1, nbl0}
  logic [4:0]      s_strb, p_strb;
  logic [AD_W-1:0] s_ad, p_ad;

  fsmc_sync #(.W(5), .STAGES(SYNC_STAGES)) u_sync_strb (
    .clk     (clk),
    .rst     (rst),
    .rst_val (5'b11111),
    .d       ({fsmc_ne1, fsmc_nwe, fsmc_noe, fsmc_nbl1, fsmc_nbl0}),
    .q       (s_strb)
  );

  fsmc_sync #(.W(AD_W), .STAGES(SYNC_STAGES)) u_sync_ad (
    .clk     (clk),
    .rst     (rst),
    .rst_val ({AD_W{1'b0}}),
    .d       ({fsmc_a, fsmc_d_in}),
    .q       (s_ad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_strb <= 5'b11111;
      p_ad   <= '0;
    end else begin
      p_strb <= s_strb;
      p_ad   <= s_ad;
    end
  end

  logic wr_act, rd_act, p_wr_act, p_rd_act;
  logic wr_trig, rd_trig, rd_fall;

  assign wr_act   = ~s_strb[4] & ~s_strb[3];
  assign rd_act   = ~s_strb[4] & ~s_strb[2] & s_strb[3];
  assign p_wr_act = ~p_strb[4] & ~p_strb[3];
  assign p_rd_act = ~p_strb[4] & ~p_strb[2] & p_strb[3];

  assign wr_trig = p_wr_act & ~wr_act;
  assign rd_trig = ~p_rd_act & rd_act;
  assign rd_fall = p_rd_act & ~rd_act;

  // Write capture stage: latch the last values seen while the strobe was active.
  logic              wr_pend;
  logic [ADDR_W-1:0] cap_a;
  logic [DATA_W-1:0] cap_d;
  logic [1:0]        cap_be;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend <= 1'b0;
      cap_a   <= '0;
      cap_d   <= '0;
      cap_be  <= '0;
    end else begin
      wr_pend <= wr_trig;
      if (wr_trig) begin
        cap_a  <= p_ad[AD_W-1:DATA_W];
        cap_d  <= p_ad[DATA_W-1:0];
        cap_be <= ~p_strb[1:0];
      end
    end
  end

  fsmc_state_t       state, nxt;
  logic              aborted, aborted_n;
  logic              req_valid_n, req_we_n, fsmc_d_oe_n, err_n;
  logic [ADDR_W-1:0] req_addr_n;
  logic [DATA_W-1:0] req_wdata_n, fsmc_d_out_n;
  logic [1:0]        req_be_n;
  logic              nwait_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      aborted    <= 1'b0;
      req_valid  <= 1'b0;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_be     <= '0;
      fsmc_d_out <= '0;
      fsmc_d_oe  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= nxt;
      aborted    <= aborted_n;
      req_valid  <= req_valid_n;
      req_we     <= req_we_n;
      req_addr   <= req_addr_n;
      req_wdata  <= req_wdata_n;
      req_be     <= req_be_n;
      fsmc_d_out <= fsmc_d_out_n;
      fsmc_d_oe  <= fsmc_d_oe_n;
      err_sticky <= err_n;
    end
  end

  always_comb begin
    nxt          = state;
    aborted_n    = aborted;
    req_valid_n  = req_valid;
    req_we_n     = req_we;
    req_addr_n   = req_addr;
    req_wdata_n  = req_wdata;
    req_be_n     = req_be;
    fsmc_d_out_n = fsmc_d_out;
    fsmc_d_oe_n  = fsmc_d_oe;
    err_n        = err_sticky;

    // Any strobe completing outside IDLE is dropped and flagged.
    if (state != IDLE && (wr_pend || rd_trig)) err_n = 1'b1;

    case (state)
      IDLE: begin
        if (wr_pend) begin
          nxt         = WR_REQ;
          req_valid_n = 1'b1;
          req_we_n    = 1'b1;
          req_addr_n  = cap_a;
          req_wdata_n = cap_d;
          req_be_n    = cap_be;
          if (rd_trig) err_n = 1'b1;
        end else if (rd_trig) begin
          nxt         = RD_REQ;
          req_valid_n = 1'b1;
          req_we_n    = 1'b0;
          req_addr_n  = s_ad[AD_W-1:DATA_W];
          req_be_n    = 2'b11;
          aborted_n   = 1'b0;
        end
      end
      WR_REQ: begin
        if (req_ready) begin
          req_valid_n = 1'b0;
          nxt         = IDLE;
        end
      end
      RD_REQ: begin
        if (rd_fall) begin
          aborted_n = 1'b1;
          err_n     = 1'b1;
        end
        if (req_ready) begin
          req_valid_n = 1'b0;
          nxt         = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_fall) begin
          aborted_n = 1'b1;
          err_n     = 1'b1;
        end
        if (rsp_valid) begin
          if (aborted || rd_fall) begin
            nxt = IDLE;
          end else begin
            nxt          = RD_HOLD;
            fsmc_d_out_n = rsp_rdata;
            fsmc_d_oe_n  = 1'b1;
          end
        end
      end
      RD_HOLD: begin
        if (!rd_act) begin
          fsmc_d_oe_n = 1'b0;
          nxt         = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase

    // NWAIT stays low through the cycle in which the pads start driving.
    nwait_n = !((nxt == WR_REQ) || (nxt == RD_REQ) || (nxt == RD_WAIT) ||
                (state == RD_WAIT && nxt == RD_HOLD));
  end

`ifdef FSMC_NWAIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsmc_nwait <= 1'b1;
    else     fsmc_nwait <= nwait_n;
  end
`else
  logic nwait_unused;
  assign nwait_unused = nwait_n;
`endif

endmodule

// File: tb/tb_fsmc_target.sv
// tb/tb_fsmc_target.sv - directed self-checking bench for fsmc_target
module tb_fsmc_target;
  import fsmc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] fsmc_a = '0;
  logic [15:0] fsmc_d_in = '0;
  logic [15:0] fsmc_d_out;
  logic        fsmc_d_oe;
  logic        fsmc_ne1 = 1'b1, fsmc_nwe = 1'b1, fsmc_noe = 1'b1;
  logic        fsmc_nbl1 = 1'b1, fsmc_nbl0 = 1'b1;
  logic        req_valid, req_we;
  logic        req_ready = 1'b0;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid = 1'b0;
  logic [15:0] rsp_rdata = '0;
  logic        err_sticky;
`ifdef FSMC_NWAIT_EN
  logic        fsmc_nwait;
`endif

  int vectors = 0;
  int miscompares = 0;
  int accepts = 0;
  logic oe_seen = 1'b0;

  always #5 clk = ~clk;

  fsmc_target dut (
    .clk        (clk),
    .rst        (rst),
    .fsmc_a     (fsmc_a),
    .fsmc_d_in  (fsmc_d_in),
    .fsmc_d_out (fsmc_d_out),
    .fsmc_d_oe  (fsmc_d_oe),
    .fsmc_ne1   (fsmc_ne1),
    .fsmc_nwe   (fsmc_nwe),
    .fsmc_noe   (fsmc_noe),
    .fsmc_nbl1  (fsmc_nbl1),
    .fsmc_nbl0  (fsmc_nbl0),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .err_sticky (err_sticky)
`ifdef FSMC_NWAIT_EN
    ,
    .fsmc_nwait (fsmc_nwait)
`endif
  );

  always @(posedge clk) begin
    if (req_valid && req_ready) accepts++;
    if (fsmc_d_oe) oe_seen = 1'b1;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic accept_pulse();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !req_valid; i++) tick();
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({req_valid, req_we, fsmc_d_oe, err_sticky} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b expected 0000", {req_valid, req_we, fsmc_d_oe, err_sticky});
    end
    vectors++;
    if ({req_addr, req_wdata, req_be, fsmc_d_out} !== 50'd0) begin
      miscompares++;
      $display("FAIL reset_data: got addr=%h wdata=%h be=%b dout=%h expected all 0",
               req_addr, req_wdata, req_be, fsmc_d_out);
    end
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_write_basic();
    int base;
    base = accepts;
    fsmc_a = 16'h1000; fsmc_d_in = 16'hAAAA; fsmc_nbl1 = 1'b0; fsmc_nbl0 = 1'b0;
    fsmc_ne1 = 1'b0; fsmc_nwe = 1'b0;
    tick(5000);
    vectors++;
    if (req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_hold_no_req: got valid=%b expected 0", req_valid);
    end
    fsmc_ne1 = 1'b1; fsmc_nwe = 1'b1;
    tick(3);
    vectors++;
    if (req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_latency_early: got valid=%b at cycle 3 expected 0", req_valid);
    end
    tick();
    vectors++;
    if (req_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_latency: got valid=%b at cycle 4 expected 1", req_valid);
    end
    vectors++;
    if ({req_we, req_addr, req_wdata, req_be} !== {1'b1, 16'h1000, 16'hAAAA, 2'b11}) begin
      miscompares++;
      $display("FAIL wr_fields: got we=%b addr=%h wdata=%h be=%b expected 1 1000 aaaa 11",
               req_we, req_addr, req_wdata, req_be);
    end
    accept_pulse();
    tick(10);
    vectors++;
    if (req_valid !== 1'b0 || accepts - base !== 1) begin
      miscompares++;
      $display("FAIL wr_single: got valid=%b accepts=%0d expected 0 and 1", req_valid, accepts - base);
    end
    fsmc_nbl1 = 1'b1; fsmc_nbl0 = 1'b1;
  endtask

  task automatic test_write_backpressure();
    int base;
    logic stable;
    base = accepts;
    fsmc_a = 16'h1111; fsmc_d_in = 16'h5555; fsmc_nbl1 = 1'b1; fsmc_nbl0 = 1'b0;
    fsmc_ne1 = 1'b0; fsmc_nwe = 1'b0;
    tick(10);
    fsmc_ne1 = 1'b1; fsmc_nwe = 1'b1; fsmc_nbl0 = 1'b1;
    wait_valid(20);
    vectors++;
    if (req_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_valid: got valid=%b expected 1", req_valid);
    end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if ({req_valid, req_we, req_addr, req_wdata, req_be} !== {2'b11, 16'h1111, 16'h5555, 2'b01})
        stable = 1'b0;
      tick();
    end
    vectors++;
    if (stable !== 1'b1 || req_be !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_stable: got be=%b addr=%h wdata=%h stable=%b expected 01 1111 5555 1",
               req_be, req_addr, req_wdata, stable);
    end
    accept_pulse();
    tick(5);
    vectors++;
    if (req_valid !== 1'b0 || accepts - base !== 1) begin
      miscompares++;
      $display("FAIL bp_single: got valid=%b accepts=%0d expected 0 and 1", req_valid, accepts - base);
    end
  endtask

  task automatic test_read();
    logic held;
    fsmc_a = 16'h1000; fsmc_ne1 = 1'b0; fsmc_noe = 1'b0;
    wait_valid(20);
    vectors++;
    if ({req_valid, req_we, req_addr, req_be} !== {2'b10, 16'h1000, 2'b11}) begin
      miscompares++;
      $display("FAIL rd_req: got valid=%b we=%b addr=%h be=%b expected 1 0 1000 11",
               req_valid, req_we, req_addr, req_be);
    end
    accept_pulse();
    tick(8);
    vectors++;
    if (fsmc_d_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_oe_early: got oe=%b expected 0", fsmc_d_oe);
    end
    rsp_valid = 1'b1; rsp_rdata = 16'hAAAA;
    tick();
    rsp_valid = 1'b0; rsp_rdata = 16'h0000;
    held = 1'b1;
    for (int i = 0; i < 4990; i++) begin
      if (fsmc_d_oe !== 1'b1 || fsmc_d_out !== 16'hAAAA) held = 1'b0;
      tick();
    end
    vectors++;
    if (held !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_drive: got oe=%b dout=%h held=%b expected 1 aaaa 1", fsmc_d_oe, fsmc_d_out, held);
    end
    fsmc_ne1 = 1'b1; fsmc_noe = 1'b1;
    tick(2);
    vectors++;
    if (fsmc_d_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_oe_release_early: got oe=%b expected 1", fsmc_d_oe);
    end
    tick();
    vectors++;
    if (fsmc_d_oe !== 1'b0 || fsmc_d_out !== 16'hAAAA) begin
      miscompares++;
      $display("FAIL rd_oe_release: got oe=%b dout=%h expected 0 aaaa", fsmc_d_oe, fsmc_d_out);
    end
    rsp_valid = 1'b1; rsp_rdata = 16'h1234;
    tick();
    rsp_valid = 1'b0;
    tick(2);
    vectors++;
    if ({fsmc_d_oe, fsmc_d_out, err_sticky} !== {1'b0, 16'hAAAA, 1'b0}) begin
      miscompares++;
      $display("FAIL rsp_ignored: got oe=%b dout=%h err=%b expected 0 aaaa 0",
               fsmc_d_oe, fsmc_d_out, err_sticky);
    end
  endtask

  task automatic test_write_overlap();
    int base;
    base = accepts;
    fsmc_a = 16'h0100; fsmc_d_in = 16'h0001; fsmc_nbl1 = 1'b0; fsmc_nbl0 = 1'b0;
    fsmc_ne1 = 1'b0; fsmc_nwe = 1'b0;
    tick(10);
    fsmc_ne1 = 1'b1; fsmc_nwe = 1'b1;
    wait_valid(20);
    tick(3);
    fsmc_a = 16'h0200; fsmc_d_in = 16'h0002;
    fsmc_ne1 = 1'b0; fsmc_nwe = 1'b0;
    tick(10);
    fsmc_ne1 = 1'b1; fsmc_nwe = 1'b1;
    tick(6);
    vectors++;
    if ({req_valid, err_sticky, req_addr, req_wdata} !== {2'b11, 16'h0100, 16'h0001}) begin
      miscompares++;
      $display("FAIL overlap_first: got valid=%b err=%b addr=%h wdata=%h expected 1 1 0100 0001",
               req_valid, err_sticky, req_addr, req_wdata);
    end
    accept_pulse();
    tick(10);
    vectors++;
    if (req_valid !== 1'b0 || accepts - base !== 1) begin
      miscompares++;
      $display("FAIL overlap_single: got valid=%b accepts=%0d expected 0 and 1", req_valid, accepts - base);
    end
    fsmc_nbl1 = 1'b1; fsmc_nbl0 = 1'b1;
  endtask

  task automatic test_reset_mid_read();
    fsmc_a = 16'h3000; fsmc_ne1 = 1'b0; fsmc_noe = 1'b0;
    wait_valid(20);
    accept_pulse();
    tick(2);
    vectors++;
    if (dut.state !== RD_WAIT || err_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_setup: got state=%0d err=%b expected %0d 1", dut.state, err_sticky, RD_WAIT);
    end
    rsp_valid = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if ({req_valid, fsmc_d_oe, err_sticky} !== 3'b000) begin
      miscompares++;
      $display("FAIL rstmid_async: got valid=%b oe=%b err=%b expected 000", req_valid, fsmc_d_oe, err_sticky);
    end
    fsmc_ne1 = 1'b1; fsmc_noe = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    fsmc_a = 16'h3000; fsmc_ne1 = 1'b0; fsmc_noe = 1'b0;
    wait_valid(20);
    vectors++;
    if ({req_valid, req_we, req_addr} !== {2'b10, 16'h3000}) begin
      miscompares++;
      $display("FAIL rstmid_next_req: got valid=%b we=%b addr=%h expected 1 0 3000", req_valid, req_we, req_addr);
    end
    accept_pulse();
    tick(3);
    rsp_valid = 1'b1; rsp_rdata = 16'h5A5A;
    tick();
    rsp_valid = 1'b0;
    vectors++;
    if ({fsmc_d_oe, fsmc_d_out, err_sticky} !== {1'b1, 16'h5A5A, 1'b0}) begin
      miscompares++;
      $display("FAIL rstmid_next_data: got oe=%b dout=%h err=%b expected 1 5a5a 0",
               fsmc_d_oe, fsmc_d_out, err_sticky);
    end
    fsmc_ne1 = 1'b1; fsmc_noe = 1'b1;
    tick(5);
  endtask

  task automatic test_read_abort();
    oe_seen = 1'b0;
    fsmc_a = 16'h2222; fsmc_ne1 = 1'b0; fsmc_noe = 1'b0;
    wait_valid(20);
    fsmc_ne1 = 1'b1; fsmc_noe = 1'b1;
    tick(5);
    vectors++;
    if ({req_valid, req_addr, err_sticky} !== {1'b1, 16'h2222, 1'b1}) begin
      miscompares++;
      $display("FAIL abort_hold: got valid=%b addr=%h err=%b expected 1 2222 1", req_valid, req_addr, err_sticky);
    end
    accept_pulse();
    tick(2);
    rsp_valid = 1'b1; rsp_rdata = 16'h3333;
    tick();
    rsp_valid = 1'b0;
    tick(2);
    vectors++;
    if ({oe_seen, fsmc_d_out, err_sticky} !== {1'b0, 16'h5A5A, 1'b1}) begin
      miscompares++;
      $display("FAIL abort_discard: got oe_seen=%b dout=%h err=%b expected 0 5a5a 1",
               oe_seen, fsmc_d_out, err_sticky);
    end
    vectors++;
    if (dut.state !== IDLE) begin
      miscompares++;
      $display("FAIL abort_idle: got state=%0d expected %0d", dut.state, IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_backpressure();
    test_read();
    test_write_overlap();
    test_reset_mid_read();
    test_read_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
